tlp_tx_arb: RTL
===============

Name: tlp_tx_arb

Overview:
- Parametrised N-way, packet-atomic arbiter that merges several TLP-producing engines onto the single PCIe TX stream (64-bit data, SOP/EOP framing).
- Successor to the fixed single-sender TX path. Lets register-completion, f2c DMA and future engines share txData/txValid/txReady/txSOP/txEOP without interleaving packets.
- Round-robin fairness, registered output stage, orphan-beat detection.

Parameters:
NUM_SRC, 4, number of source ports (2..8)
DATA_WIDTH, 64, beat width in bits
CNT_WIDTH, 16, width of the saturating drop counter

Ports:
pcieClk_in  in  1  125MHz PCIe core clock; all logic on rising edge
reset_in  in  1  asynchronous, active-high reset
srcData_in  in  NUM_SRC*DATA_WIDTH  packed beats; source i at [i*DATA_WIDTH +: DATA_WIDTH]
srcValid_in  in  NUM_SRC  per-source beat valid
srcReady_out  out  NUM_SRC  per-source beat accept
srcSOP_in  in  NUM_SRC  per-source start-of-packet
srcEOP_in  in  NUM_SRC  per-source end-of-packet
txData_out  out  DATA_WIDTH  merged beat to PCIe core
txValid_out  out  1  merged valid
txReady_in  in  1  PCIe core accept
txSOP_out  out  1  merged SOP
txEOP_out  out  1  merged EOP
grant_out  out  NUM_SRC  one-hot owner of the packet in flight; 0 when idle
busy_out  out  1  high while state is PKT
dropCount_out  out  CNT_WIDTH  saturating count of discarded orphan beats

Behaviour:
- Clock and reset: one clock (pcieClk_in); reset_in is asynchronous, active-high.
- Reset values:
  - txValid_out=0, txSOP_out=0, txEOP_out=0, txData_out=0
  - grant_out=0, busy_out=0, dropCount_out=0
  - round-robin pointer = NUM_SRC-1, so source 0 wins first
  - state=IDLE
- Output register:
  - A beat is accepted from a source in cycle N and appears on tx* in cycle N+1.
  - The register loads when (!txValid_out || txReady_in); call this "advance".
  - txValid_out drops only when the held beat is taken with no new beat loaded.
  - Full throughput is 1 beat/cycle when txReady_in stays high.
- srcReady_out:
  - Combinational from grant/arbitration and advance.
  - Never depends on the same source's srcValid_in.
- State IDLE:
  - Candidates are sources with srcValid_in&srcSOP_in.
  - The winner is the first candidate found scanning from pointer+1 upward with wrap modulo NUM_SRC.
  - If advance, accept the winner's SOP beat.
  - If that beat also has EOP (single-beat TLP), stay IDLE and set pointer=winner.
  - Otherwise go to PKT, set grant_out=onehot(winner), busy_out=1.
  - No candidate: tx register drains normally; no state change.
- State PKT:
  - Only the granted source sees srcReady_out=advance; all others see 0.
  - A granted source deasserting valid mid-packet stalls the output, with no timeout.
  - On the accepted beat with EOP: go to IDLE, pointer=granted index, grant_out=0, busy_out=0.
  - An SOP asserted on a non-first beat is ignored; the beat passes with txSOP_out=0.
- Orphan beats:
  - An orphan beat is a valid beat without SOP on a non-granted source.
  - Orphan beats are consumed (srcReady_out=1, independent of txReady_in) and never forwarded.
  - Each orphan beat increments dropCount_out by the number of orphan beats that cycle, saturating at all-ones.
  - Orphan beats do not affect arbitration.
- Simultaneous events:
  - EOP accepted and a new SOP waiting in the same cycle: the new packet is arbitrated on the next cycle, giving one bubble.
  - Advance and drain in the same cycle are legal.
- Back-to-back same source: a source only wins again if it is the sole candidate, or if the pointer scan reaches it after all other candidates.
- Reset mid-packet: state, grant and tx register are cleared immediately (asynchronous). The partially sent TLP is abandoned. Sources must also be reset.

Optional Feature:
- Macro: TLP_TX_ARB_PRIO0_EN.
- Defined: source 0 has strict priority in IDLE; if it has a pending SOP it wins regardless of the pointer, and the pointer is not updated on its wins. Sources 1..NUM_SRC-1 round-robin among themselves. The packet lock in PKT is unchanged, so source 0 never pre-empts a packet already in flight.
- Undefined: pure round-robin across all sources, as above.

Test Plan:
- Reset, then source 2 sends a 3-beat TLP (0xA0,0xA1,0xA2) with txReady_in=1 -> tx shows the beats on cycles N+1..N+3; SOP on 0xA0 and EOP on 0xA2; grant_out=4'b0100 during PKT; busy_out=0 after the EOP beat.
- All 4 sources each hold a pending 2-beat TLP -> output packet order is 0,1,2,3, then 0 again when re-offered; no beat interleaving; exactly one bubble between packets.
- Source 1 mid-packet with txReady_in low for 5 cycles -> txValid_out stays 1 with the data held stable; srcReady_out=0; no beat lost or duplicated.
- Source 3 drives 3 valid beats without SOP while idle -> srcReady_out[3]=1, nothing on tx, dropCount_out=3; with the count preset near max, it saturates at 0xFFFF.
- Single-beat TLPs (SOP&EOP) from sources 0 and 1 every cycle -> they alternate 0,1,0,1; state stays IDLE; busy_out stays 0.
- Assert reset_in during the second beat of a 4-beat packet -> all outputs return to reset values within the same cycle; the next SOP from source 0 is accepted normally. With TLP_TX_ARB_PRIO0_EN, sources 0 and 2 both pending after a source 2 win -> source 0 is granted first.

Source files
------------

// File: rtl/tlp_tx_arb.sv
// tlp_tx_arb: N-way packet-atomic round-robin arbiter onto the PCIe TX stream.
// Optional macro TLP_TX_ARB_PRIO0_EN gives source 0 strict priority while idle.
module tlp_tx_arb #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          pcieClk_in,
    input  logic                          reset_in,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] srcData_in,
    input  logic [NUM_SRC-1:0]            srcValid_in,
    output logic [NUM_SRC-1:0]            srcReady_out,
    input  logic [NUM_SRC-1:0]            srcSOP_in,
    input  logic [NUM_SRC-1:0]            srcEOP_in,
    output logic [DATA_WIDTH-1:0]         txData_out,
    output logic                          txValid_out,
    input  logic                          txReady_in,
    output logic                          txSOP_out,
    output logic                          txEOP_out,
    output logic [NUM_SRC-1:0]            grant_out,
    output logic                          busy_out,
    output logic [CNT_WIDTH-1:0]          dropCount_out
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int POP_W = $clog2(NUM_SRC + 1);
    localparam int SUM_W = CNT_WIDTH + 1;

`ifdef TLP_TX_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptrNext;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W-1:0]   grantIdxNext;
    logic               gap;
    logic               gapNext;

    logic               advance;
    logic               arbOpen;
    logic [NUM_SRC-1:0] grantMask;
    logic [NUM_SRC-1:0] sopReady;
    logic [NUM_SRC-1:0] orphan;
    logic               winValid;
    logic [IDX_W-1:0]   winIdx;

    logic                  load;
    logic                  loadSop;
    logic                  loadEop;
    logic [DATA_WIDTH-1:0] loadData;

    logic [POP_W-1:0]     orphanCnt;
    logic [SUM_W-1:0]     cntSum;
    logic [CNT_WIDTH-1:0] cntNext;

    assign advance   = !txValid_out || txReady_in;
    // The cycle right after a packet ends is a deliberate bubble: no new SOP.
    assign arbOpen   = (state == IDLE) && !gap;
    assign grantMask = (state == PKT) ? (NUM_SRC'(1) << grantIdx) : '0;
    assign grant_out = grantMask;
    assign busy_out  = (state == PKT);

    // Non-SOP beats on non-owners are orphans; owner beats pass regardless of SOP.
    assign orphan = srcValid_in & ~srcSOP_in & ~grantMask;

    // Ready per source never looks at that source's own valid.
    assign srcReady_out = (~srcSOP_in & ~grantMask)
                        | ((sopReady | grantMask) & {NUM_SRC{advance}});

    // Scan from pointer+1 with wrap; a source is SOP-ready if no earlier candidate.
    always_comb begin
        int   idx;
        logic found;
        sopReady = '0;
        winValid = 1'b0;
        winIdx   = '0;
        found    = 1'b0;
        idx      = 0;
        if (PRIO0 && arbOpen) begin
            sopReady[0] = srcSOP_in[0];
            if (srcValid_in[0] && srcSOP_in[0]) begin
                found    = 1'b1;
                winValid = 1'b1;
                winIdx   = '0;
            end
        end
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (arbOpen && !(PRIO0 && idx == 0)) begin
                sopReady[idx] = srcSOP_in[idx] && !found;
                if (srcValid_in[idx] && srcSOP_in[idx] && !found) begin
                    found    = 1'b1;
                    winValid = 1'b1;
                    winIdx   = IDX_W'(idx);
                end
            end
        end
    end

    // Next-state, pointer update and tx register load selection.
    always_comb begin
        stateNext    = state;
        ptrNext      = ptr;
        grantIdxNext = grantIdx;
        gapNext      = 1'b0;
        load         = 1'b0;
        loadSop      = 1'b0;
        loadEop      = 1'b0;
        loadData     = '0;
        unique case (state)
            IDLE: begin
                if (advance && winValid) begin
                    load     = 1'b1;
                    loadSop  = 1'b1;
                    loadEop  = srcEOP_in[winIdx];
                    loadData = srcData_in[int'(winIdx)*DATA_WIDTH +: DATA_WIDTH];
                    if (srcEOP_in[winIdx]) begin
                        if (!(PRIO0 && winIdx == '0)) begin
                            ptrNext = winIdx;
                        end
                    end else begin
                        stateNext    = PKT;
                        grantIdxNext = winIdx;
                    end
                end
            end
            PKT: begin
                if (advance && srcValid_in[grantIdx]) begin
                    load     = 1'b1;
                    loadEop  = srcEOP_in[grantIdx];
                    loadData = srcData_in[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
                    if (srcEOP_in[grantIdx]) begin
                        stateNext = IDLE;
                        gapNext   = 1'b1;
                        if (!(PRIO0 && grantIdx == '0)) begin
                            ptrNext = grantIdx;
                        end
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Orphan population count and saturating drop counter next value.
    always_comb begin
        orphanCnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            orphanCnt = orphanCnt + POP_W'(orphan[i]);
        end
        cntSum  = {1'b0, dropCount_out} + SUM_W'(orphanCnt);
        cntNext = cntSum[SUM_W-1] ? '1 : cntSum[CNT_WIDTH-1:0];
    end

    // Arbiter state, pointer and owner registers.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NUM_SRC - 1);
            grantIdx <= '0;
            gap      <= 1'b0;
        end else begin
            state    <= stateNext;
            ptr      <= ptrNext;
            grantIdx <= grantIdxNext;
            gap      <= gapNext;
        end
    end

    // Output beat register: loads on advance, drains when nothing new arrives.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            txValid_out <= 1'b0;
            txSOP_out   <= 1'b0;
            txEOP_out   <= 1'b0;
            txData_out  <= '0;
        end else if (advance) begin
            if (load) begin
                txValid_out <= 1'b1;
                txSOP_out   <= loadSop;
                txEOP_out   <= loadEop;
                txData_out  <= loadData;
            end else begin
                txValid_out <= 1'b0;
                txSOP_out   <= 1'b0;
                txEOP_out   <= 1'b0;
            end
        end
    end

    // Saturating count of discarded orphan beats.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            dropCount_out <= '0;
        end else begin
            dropCount_out <= cntNext;
        end
    end

endmodule
